uart_fifo_ctl: RTL
==================

# uart_fifo_ctl

Parametrised UART controller: full-duplex RX/TX engines with configurable baud, data width and FIFO depth, a valid/ready host byte interface, and a hardware echo mode. It is the next-generation top-level UART controller for the Nexys board. The echo mode replaces the single-switch I/O controller, and `led` still mirrors the last good received word. All logic is on `posedge clk`.

## Interface

Parameters
- `CLK_HZ`, 100000000, system clock frequency.
- `BAUD`, 115200, line rate.
  - `DIV = CLK_HZ/BAUD`, integer truncation, clock cycles per bit.
  - Requirement: `DIV >= 4`.
- `DATA_BITS`, 8, data bits per frame (5..9). Framing is 1 start bit, no parity, 1 stop bit.
- `FIFO_DEPTH`, 16, entries per FIFO. Must be a power of two and at least 2.

Ports
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input, idle high.
- `tx` out 1: serial output, idle high.
- `echo` in 1: 1 = received words are retransmitted in hardware and the host interface is blocked.
- `led` out DATA_BITS: last word received with a valid stop bit.
- `tx_data` in DATA_BITS: host word to send.
- `tx_valid` in 1: host offers `tx_data`.
- `tx_ready` out 1: TX FIFO accepts. Equals `!tx_full && !echo`.
- `rx_data` out DATA_BITS: RX FIFO head.
- `rx_valid` out 1: RX FIFO non-empty and `!echo`.
- `rx_ready` in 1: host pops the RX FIFO head.
- `clr_err` in 1: clears the sticky error flags.
- `rx_overrun` out 1: sticky; a good word was dropped because the RX FIFO was full.
- `frame_err` out 1: sticky; a stop bit was sampled low.

## Operation

RX input
- `rx` passes through a 2-flop synchronizer, reset to 1.

RX FSM (IDLE, START, DATA, STOP), driven by a bit counter `cnt` that counts 0..DIV-1:
- IDLE: synchronized `rx == 0` → START, `cnt = 0`.
- START: at `cnt == DIV/2 - 1`, sample the line.
  - Line low → DATA.
  - Line high → IDLE (glitch, nothing recorded).
- DATA: sample every DIV cycles, LSB first. After DATA_BITS samples → STOP.
- STOP: sample after DIV cycles, then return to IDLE in all cases.
  - Line high: `led <=` word.
    - RX FIFO not full: push the word.
    - RX FIFO full: drop the word and set `rx_overrun`.
  - Line low: set `frame_err`, discard the word, `led` unchanged.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: TX FIFO non-empty → pop the head into the shift register and go to START on the next cycle.
- Each bit state lasts exactly DIV cycles.
  - START drives 0.
  - DATA drives DATA_BITS bits, LSB first.
  - STOP drives 1.
- Back-to-back frames are separated by exactly one idle-high cycle (the IDLE pop cycle).

FIFOs
- Circular buffers with `$clog2(FIFO_DEPTH)`-bit pointers that wrap naturally. Occupancy counter is one bit wider.
- Push on full is ignored.
- Pop on empty is ignored.
- Push and pop in the same cycle when non-empty and not full: both occur and the count is unchanged.
- No fall-through: a word pushed into an empty FIFO is visible at the head the next cycle.

Echo mode
- When `echo = 1`, one word per cycle moves from the RX FIFO head to the TX FIFO, when RX is non-empty and TX is not full.
- The host `rx_valid` and `tx_ready` are forced to 0 while `echo = 1`.
- `echo` is sampled every cycle. Toggling it never splits or corrupts a word; in-flight frames complete.

Error flags
- `clr_err` clears both flags.
- If an error event and `clr_err` occur in the same cycle, the set wins.

## Timing

Reset values
- `tx = 1`, `led = 0`, `rx_valid = 0`, `rx_overrun = 0`, `frame_err = 0`.
- Both FIFOs are empty and both FSMs are in IDLE.
- `tx_ready = 0` while `rst` is high. It may be 1 from the first cycle after reset.

Reset mid-operation
- Reset aborts any frame and flushes both FIFOs.
- `tx` is high on the cycle after `rst` is sampled.

Latencies
- RX: `rx` falling edge to START entry is 2–3 cycles (synchronizer).
- RX: stop-bit sample cycle → `rx_valid = 1` and `led` updated on the next cycle.
- TX: host push in cycle N with TX idle and FIFO empty → pop at N+1, `tx` falls at N+2.
- TX frame length: `(DATA_BITS+2)*DIV` cycles.
- Echo: word push into RX FIFO → TX FIFO entry 1 cycle later → `tx` start bit 2 cycles after that.

Interface rules
- The host handshake completes in the same cycle as `valid && ready`.
- `rx_data` is stable while `rx_valid && !rx_ready`.

## Test plan

All scenarios use `CLK_HZ = 1000000`, `BAUD = 100000` (DIV = 10), `DATA_BITS = 8`, `FIFO_DEPTH = 16`.

- **RX good frame:** drive 0xA5 on `rx` (10 cycles/bit) → `rx_valid = 1`, `rx_data = 0xA5`, `led = 0xA5`, no error flags; `rx_ready` pulse → `rx_valid = 0`.
- **TX frame:** push 0x3C with TX idle → `tx` falls 2 cycles later and emits 0,0,0,1,1,1,1,0,0,1 (start, 0x3C LSB first, stop), 10 cycles each (100 cycles total); two back-to-back pushes → exactly one idle-high cycle between frames.
- **Echo mode:** `echo = 1`, receive 0x55 → `tx` retransmits 0x55; `rx_valid` and `tx_ready` stay 0 throughout.
- **Framing error:** send 0x12 with a low stop bit → `frame_err = 1`, RX FIFO stays empty, `led` unchanged; `clr_err` → `frame_err = 0`.
- **Overrun:** send 17 words 0x00..0x10 with `rx_ready = 0` → 16 words stored in order, `rx_overrun = 1`, `led = 0x10`; draining returns 0x00..0x0F.
- **Reset mid-frame:** assert `rst` during the 4th TX data bit with 3 words queued → `tx = 1` on the next cycle, both FIFOs empty, no further frames sent after release.

Source files
------------

// File: rtl/uart_fifo_ctl.sv
// Full-duplex UART with RX/TX FIFOs, host valid/ready byte port and hardware echo.
// RX word reaches the FIFO the cycle after its stop sample; TX starts two cycles after a push into an idle engine.

module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

module uart_fifo_ctl #(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 tx,
   input  logic                 echo,
   output logic [DATA_BITS-1:0] led,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 clr_err,
   output logic                 rx_overrun,
   output logic                 frame_err
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               rx_state, tx_state;
   logic                 rx_s1, rx_s2;
   logic [CW-1:0]        rx_cnt, tx_cnt;
   logic [BW-1:0]        rx_bit, tx_bit;
   logic [DATA_BITS-1:0] rx_shift, tx_shift;
   logic [DATA_BITS-1:0] rx_head, tx_head, tx_push_data;
   logic                 rx_empty, rx_full, tx_empty, tx_full;
   logic                 rx_stop_tick, rx_push, rx_pop, tx_push, tx_pop, echo_mv;

   assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == LAST_CNT);
   assign rx_push      = rx_stop_tick && rx_s2;
   assign echo_mv      = echo && !rx_empty && !tx_full;
   assign rx_pop       = echo_mv || (!echo && rx_ready);
   assign tx_ready     = !rst && !tx_full && !echo;
   assign tx_push      = echo_mv || (tx_valid && tx_ready);
   assign tx_push_data = echo ? rx_head : tx_data;
   assign tx_pop       = (tx_state == S_IDLE) && !tx_empty;
   assign rx_valid     = !rx_empty && !echo;
   assign rx_data      = rx_head;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
      .head(rx_head), .empty(rx_empty), .full(rx_full)
   );

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .push_data(tx_push_data), .pop(tx_pop),
      .head(tx_head), .empty(tx_empty), .full(tx_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         led      <= '0;
      end else begin
         case (rx_state)
            S_IDLE: if (!rx_s2) begin
               rx_state <= S_START;
               rx_cnt   <= '0;
            end
            // A start bit that is high again at mid-bit is treated as a glitch.
            S_START: if (rx_cnt == HALF_CNT) begin
               rx_cnt   <= '0;
               rx_bit   <= '0;
               rx_state <= rx_s2 ? S_IDLE : S_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            S_DATA: if (rx_cnt == LAST_CNT) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
               rx_bit   <= rx_bit + 1'b1;
               if (rx_bit == LAST_BIT) rx_state <= S_STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            S_STOP: if (rx_cnt == LAST_CNT) begin
               rx_cnt   <= '0;
               rx_state <= S_IDLE;
               if (rx_s2) led <= rx_shift;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (rx_push && rx_full)          rx_overrun <= 1'b1;
         else if (clr_err)                rx_overrun <= 1'b0;
         if (rx_stop_tick && !rx_s2)      frame_err  <= 1'b1;
         else if (clr_err)                frame_err  <= 1'b0;
      end
   end

   // tx is registered one state ahead so each line level lasts exactly DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            S_IDLE: begin
               tx <= 1'b1;
               if (!tx_empty) begin
                  tx_shift <= tx_head;
                  tx_cnt   <= '0;
                  tx_state <= S_START;
                  tx       <= 1'b0;
               end
            end
            S_START: if (tx_cnt == LAST_CNT) begin
               tx_cnt   <= '0;
               tx_bit   <= '0;
               tx_state <= S_DATA;
               tx       <= tx_shift[0];
            end else tx_cnt <= tx_cnt + 1'b1;
            S_DATA: if (tx_cnt == LAST_CNT) begin
               tx_cnt   <= '0;
               tx_shift <= tx_shift >> 1;
               tx_bit   <= tx_bit + 1'b1;
               if (tx_bit == LAST_BIT) begin
                  tx_state <= S_STOP;
                  tx       <= 1'b1;
               end else tx <= tx_shift[1];
            end else tx_cnt <= tx_cnt + 1'b1;
            S_STOP: if (tx_cnt == LAST_CNT) begin
               tx_cnt   <= '0;
               tx_state <= S_IDLE;
               tx       <= 1'b1;
            end else tx_cnt <= tx_cnt + 1'b1;
            default: tx_state <= S_IDLE;
         endcase
      end
   end
endmodule
